// File: rtl/sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mem_ctrl
//   Memory-stage controller for the pipelined ARM core. It turns one 32-bit
//   load or store from the EXE/MEM register into two sequential 16-bit
//   accesses on the off-chip SRAM (low half first). While an access is in
//   flight, ready stays low so the freeze logic stalls the upstream pipeline.
//
// Parameters
//   WAIT_CYCLES  cycles spent on each 16-bit half (legal 1..15)
//   BASE_ADDR    byte address that maps to SRAM word 0
//
// Ports
//   clk, rst_n           pipeline clock, asynchronous active-low reset
//   MEM_R_EN, MEM_W_EN   load / store request (store wins if both are set)
//   ALU_result           byte address of the access
//   ST_val               store data
//   readData             load result, updated on entry to DONE and then held
//   ready                0 = freeze pipeline, 1 = done or no request
//   SRAM_DQ              bidirectional data bus, driven only while writing
//   SRAM_ADDR            half-word address {word index, half select}
//   SRAM_WE_N            active-low write strobe
//   SRAM_UB_N/LB_N/CE_N/OE_N  tied low (chip always selected, both bytes)
// -----------------------------------------------------------------------------
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [16:0] idx;     // latched SRAM word index
  logic [31:0] wdata;   // latched store data
  logic [15:0] lo;      // low half captured during RD_LO

  logic [31:0] offset;
  logic        last;
  logic        lo_phase;
  logic        hi_phase;
  logic        writing;
  logic        unused_offset_bits;

  assign offset = ALU_result - BASE_ADDR;
  assign last   = (cnt == LAST_CNT);

  // Byte-within-word and bits above the 18-bit SRAM space never reach the bus.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      wdata    <= '0;
      lo       <= '0;
      readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            idx   <= offset[18:2];
            wdata <= ST_val;
            cnt   <= '0;
            state <= WR_LO;
          end else if (MEM_R_EN) begin
            idx   <= offset[18:2];
            cnt   <= '0;
            state <= RD_LO;
          end
        end
        RD_LO: begin
          if (last) begin
            lo    <= SRAM_DQ;
            cnt   <= '0;
            state <= RD_HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (last) begin
            // Only loads pass through RD_HI, so readData changes only for loads.
            readData <= {SRAM_DQ, lo};
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_LO: begin
          if (last) begin
            cnt   <= '0;
            state <= WR_HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HI: begin
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM controls are decoded from the state register alone: they are stable
  // for a whole phase, and an asynchronous reset forces IDLE, which drops the
  // write strobe and releases the bus without waiting for a clock edge.
  assign lo_phase = (state == RD_LO) || (state == WR_LO);
  assign hi_phase = (state == RD_HI) || (state == WR_HI);
  assign writing  = (state == WR_LO) || (state == WR_HI);

  assign SRAM_ADDR = lo_phase ? {idx, 1'b0} :
                     hi_phase ? {idx, 1'b1} : 18'd0;
  assign SRAM_WE_N = ~writing;
  assign SRAM_DQ   = (state == WR_LO) ? wdata[15:0]  :
                     (state == WR_HI) ? wdata[31:16] : 16'hzzzz;

  assign ready = (state == DONE) ||
                 ((state == IDLE) && !MEM_R_EN && !MEM_W_EN);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_ctrl
//   Bench for sram_mem_ctrl. Instance u_dut0 uses the default WAIT_CYCLES=2,
//   instance u_dut1 uses WAIT_CYCLES=1. Each has a small behavioural SRAM on
//   its bus. A reference memory (one 16-bit entry per half-word) predicts
//   load results and SRAM contents from the address-mapping rules.
// -----------------------------------------------------------------------------
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_en0, w_en0, r_en1, w_en1;
  logic [31:0] alu, st;
  logic        probe_en;

  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic        we_n0, we_n1;
  logic        ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;
  logic [31:0] rd0, rd1;
  logic        ready0, ready1;

  logic [15:0] mem0    [256];
  logic [15:0] mem1    [256];
  logic [15:0] ref_mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0),
    .ALU_result(alu), .ST_val(st), .readData(rd0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(r_en1), .MEM_W_EN(w_en1),
    .ALU_result(alu), .ST_val(st), .readData(rd1), .ready(ready1),
    .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  // SRAM models: read data whenever the strobe is high, write on each edge
  // with the strobe low. probe_en replaces the model with a known 0 so the
  // bench can tell whether the controller is driving the bus.
  assign dq0 = probe_en ? 16'h0000 : (we_n0 ? mem0[addr0[7:0]] : 16'hzzzz);
  assign dq1 = we_n1 ? mem1[addr1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n0) mem0[addr0[7:0]] <= dq0;
    if (!we_n1) mem1[addr1[7:0]] <= dq1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic cur_ready(input int which);
    return (which == 0) ? ready0 : ready1;
  endfunction

  function automatic logic cur_we_n(input int which);
    return (which == 0) ? we_n0 : we_n1;
  endfunction

  // One access: request sampled in cycle 0, enables dropped (and address/data
  // scrambled) from cycle 1 on. Counts frozen cycles until ready returns in
  // DONE, and flags any frozen cycle whose write strobe disagrees with the op.
  task automatic access(input int which, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        output int freeze, output logic [31:0] rd, output logic we_ok);
    freeze = 0;
    we_ok  = 1'b1;
    @(posedge clk); #1;
    alu = a; st = d;
    if (which == 0) begin w_en0 = w; r_en0 = r; end
    else            begin w_en1 = w; r_en1 = r; end
    @(negedge clk);
    if (!cur_ready(which)) freeze++;
    @(posedge clk); #1;
    w_en0 = 1'b0; r_en0 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0;
    alu = $urandom; st = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cur_ready(which)) break;
      freeze++;
      if (cur_we_n(which) !== ~w) we_ok = 1'b0;
    end
    rd = (which == 0) ? rd0 : rd1;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [7];
  int          freeze;
  logic [31:0] rd;
  logic        we_ok;
  logic [31:0] last_load;
  int          k;
  int          op;
  logic [31:0] a, d;

  initial begin
    r_en0 = 0; w_en0 = 0; r_en1 = 0; w_en1 = 0;
    alu = 0; st = 0; probe_en = 0; last_load = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0; mem1[i] = 16'h0; ref_mem[i] = 16'h0;
    end

    // Reset state
    #22 rst_n = 1'b1;
    #1;
    check("reset_ready", ready0, 1);
    check("reset_readData", rd0, 0);
    check("reset_addr", addr0, 0);
    check("reset_we_n", we_n0, 1);
    check("tie_offs", {ub0, lb0, ce0, oe0}, 0);

    // Idle: ready high, no write strobe, bus released
    probe_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", ready0, 1);
      check("idle_we_n", we_n0, 1);
      check("idle_dq_released", dq0, 16'h0000);
    end
    probe_en = 1'b0;

    // Directed vectors, applied back to back
    vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,        1'b1, 32'h00000000};
    vecs[4] = '{1'b0, 1'b1, 32'd1032, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 32'd1027, 32'h0,        1'b1, 32'h12345678};
    for (int i = 0; i < 7; i++) begin
      access(0, vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].data, freeze, rd, we_ok);
      k = int'((vecs[i].addr - 32'd1024) >> 2);
      if (vecs[i].w) begin
        ref_mem[2*k]   = vecs[i].data[15:0];
        ref_mem[2*k+1] = vecs[i].data[31:16];
      end else begin
        last_load = {ref_mem[2*k+1], ref_mem[2*k]};
      end
      check($sformatf("vec%0d_freeze", i), 32'(freeze), 32'd5);
      check($sformatf("vec%0d_we_n", i), we_ok, 1);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_readData", i), rd, vecs[i].exp_rd);
    end
    check("sram0", mem0[0], 16'h5678);
    check("sram1", mem0[1], 16'h1234);
    check("sram2", mem0[2], 16'hBEEF);
    check("sram3", mem0[3], 16'hDEAD);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 63);
      a  = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      d  = $urandom;
      op = $urandom_range(0, 2);
      if (op == 1) begin
        access(0, 1'b0, 1'b1, a, d, freeze, rd, we_ok);
        last_load = {ref_mem[2*k+1], ref_mem[2*k]};
        check("rand_load_data", rd, last_load);
      end else begin
        access(0, 1'b1, (op == 2), a, d, freeze, rd, we_ok);
        ref_mem[2*k]   = d[15:0];
        ref_mem[2*k+1] = d[31:16];
        check("rand_store_lo", mem0[2*k], ref_mem[2*k]);
        check("rand_store_hi", mem0[2*k+1], ref_mem[2*k+1]);
        check("rand_store_readData_held", rd, last_load);
      end
      check("rand_freeze", 32'(freeze), 32'd5);
      check("rand_we_n", we_ok, 1);
    end

    // WAIT_CYCLES=1 build
    access(1, 1'b1, 1'b0, 32'd1040, 32'hA5A55A5A, freeze, rd, we_ok);
    check("w1_store_freeze", 32'(freeze), 32'd3);
    check("w1_sram_lo", mem1[8], 16'h5A5A);
    check("w1_sram_hi", mem1[9], 16'hA5A5);
    access(1, 1'b0, 1'b1, 32'd1040, 32'h0, freeze, rd, we_ok);
    check("w1_load_freeze", 32'(freeze), 32'd3);
    check("w1_load_data", rd, 32'hA5A55A5A);

    // Reset in the middle of WR_HI
    @(posedge clk); #1;
    alu = 32'd1036; st = 32'h8BADF00D; w_en0 = 1'b1;
    @(posedge clk); #1;
    w_en0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("midstore_we_n_active", we_n0, 0);
    check("midstore_dq_hi", dq0, 16'h8BAD);
    check("midstore_readData_before", rd0, last_load);
    probe_en = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("abort_we_n", we_n0, 1);
    check("abort_dq_released", dq0, 16'h0000);
    check("abort_addr", addr0, 0);
    check("abort_ready", ready0, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    probe_en = 1'b0;
    @(negedge clk);
    check("post_reset_readData", rd0, 0);
    check("post_reset_ready", ready0, 1);
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, freeze, rd, we_ok);
    check("post_reset_freeze", 32'(freeze), 32'd5);
    check("post_reset_load", rd, {ref_mem[1], ref_mem[0]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
